// File: rtl/gpi_cond_pkg.sv
// Shared constants and helpers for the GPI input conditioner.
// Sized for the soft_processor 8-bit gpi bus.
package gpi_cond_pkg;

    localparam int unsigned GPI_WIDTH           = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;

    // max(1, clog2(n)): width able to hold 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << k) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One conditioned input bit: synchroniser, debounce counter,
// stable level, edge pulses and sticky change flag.
module gpi_debounce_bit
    import gpi_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic clr,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic chg_flag,
    output logic chg_next
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ   = sync2 ^ stable;
    assign accept   = differ && (cnt == CNT_LAST);
    // A new transition wins over a clear arriving in the same cycle
    assign chg_next = accept | (chg_flag & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            chg_flag <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                stable <= sync2;
            end
            rise     <= accept & sync2;
            fall     <= accept & ~sync2;
            chg_flag <= chg_next;
        end
    end

endmodule

// File: rtl/gpi_input_conditioner.sv
// Conditions raw board pins into the soft_processor gpi bus,
// with per-bit edge pulses and sticky change flags.
module gpi_input_conditioner
    import gpi_cond_pkg::*;
#(
    parameter int unsigned WIDTH           = GPI_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] gpi,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] chg_flag,
    input  logic [WIDTH-1:0] chg_clr,
    output logic             any_chg
);

    logic [WIDTH-1:0] chg_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpi_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .pin     (pin_in[i]),
            .clr     (chg_clr[i]),
            .stable  (gpi[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .chg_flag(chg_flag[i]),
            .chg_next(chg_next[i])
        );
    end

    // Built from next-state flags so it moves in step with chg_flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_chg <= 1'b0;
        end else begin
            any_chg <= |chg_next;
        end
    end

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Randomised and directed bench for gpi_input_conditioner,
// checked against a sample-window reference model.
module tb_gpi_input_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_in;
    logic [7:0] gpi;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] chg_flag;
    logic [7:0] chg_clr;
    logic       any_chg;

    int n_checks;
    int n_fail;

    logic [7:0] pq[$];
    logic [7:0] wq[$];
    logic [7:0] m_gpi;
    logic [7:0] m_rise;
    logic [7:0] m_fall;
    logic [7:0] m_chg;
    logic       m_any;

    gpi_input_conditioner #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_in  (pin_in),
        .gpi     (gpi),
        .rise    (rise),
        .fall    (fall),
        .chg_flag(chg_flag),
        .chg_clr (chg_clr),
        .any_chg (any_chg)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronised view lags the pins by two edges, zeros after reset
    task automatic model_reset();
        pq.delete();
        wq.delete();
        pq.push_back(8'h00);
        pq.push_back(8'h00);
        m_gpi  = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
        m_chg  = 8'h00;
        m_any  = 1'b0;
    endtask

    // A bit is accepted once the last D synchronised samples all disagree with it
    task automatic model_edge(input logic [7:0] p, input logic [7:0] c);
        logic [7:0] s;
        logic [7:0] acc;
        logic       all;
        pq.push_back(p);
        s = pq.pop_front();
        wq.push_back(s);
        if (wq.size() > D) void'(wq.pop_front());
        acc = 8'h00;
        if (wq.size() == D) begin
            for (int i = 0; i < 8; i++) begin
                all = 1'b1;
                foreach (wq[j]) if (wq[j][i] == m_gpi[i]) all = 1'b0;
                acc[i] = all;
            end
        end
        m_rise = acc & ~m_gpi;
        m_fall = acc & m_gpi;
        m_gpi  = m_gpi ^ acc;
        m_chg  = acc | (m_chg & ~c);
        m_any  = |m_chg;
    endtask

    task automatic compare();
        check("gpi", gpi, m_gpi);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("chg_flag", chg_flag, m_chg);
        check("any_chg", 8'(any_chg), 8'(m_any));
    endtask

    task automatic tick();
        logic [7:0] p;
        logic [7:0] c;
        p = pin_in;
        c = chg_clr;
        @(posedge clk);
        if (rst_n) model_edge(p, c);
        #1;
        compare();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_gpi", gpi, 8'h00);
        repeat (n) begin
            tick();
            check("rst_hold_gpi", gpi, 8'h00);
        end
        rst_n = 1'b1;
    endtask

    task automatic clear_flags();
        chg_clr = 8'hFF;
        tick();
        chg_clr = 8'h00;
    endtask

    task automatic settle(input logic [7:0] p);
        pin_in = p;
        repeat (D + 4) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        pin_in   = 8'hFF;
        chg_clr  = 8'h00;
        model_reset();
        #2;

        // Pins high through reset are accepted after the full latency
        do_reset(5);
        for (int e = 1; e <= D + 2; e++) begin
            tick();
            if (e < D + 2) begin
                check("rel_gpi_early", gpi, 8'h00);
            end else begin
                check("rel_gpi", gpi, 8'hFF);
                check("rel_rise", rise, 8'hFF);
                check("rel_chg", chg_flag, 8'hFF);
                check("rel_any", 8'(any_chg), 8'h01);
            end
        end
        tick();
        check("rel_rise_once", rise, 8'h00);
        clear_flags();
        settle(8'h00);
        clear_flags();

        // Clean single-bit edge
        pin_in = 8'h08;
        for (int e = 1; e <= D + 2; e++) begin
            tick();
            check("edge_fall", fall, 8'h00);
            if (e == D + 1) check("edge_gpi_early", gpi, 8'h00);
        end
        check("edge_gpi", gpi, 8'h08);
        check("edge_rise", rise, 8'h08);
        tick();
        check("edge_rise_once", rise, 8'h00);
        clear_flags();

        // Short glitch never reaches gpi
        pin_in = 8'h09;
        repeat (D - 1) tick();
        pin_in = 8'h08;
        repeat (D + 4) begin
            tick();
            check("glitch_rise", rise & 8'h01, 8'h00);
        end
        check("glitch_gpi", gpi, 8'h08);
        check("glitch_chg", chg_flag, 8'h00);

        // Several bits move together
        settle(8'h0F);
        clear_flags();
        pin_in = 8'hF0;
        repeat (D + 2) tick();
        check("simul_rise", rise, 8'hF0);
        check("simul_fall", fall, 8'h0F);
        check("simul_chg", chg_flag, 8'hFF);
        clear_flags();

        // Set beats clear in the same cycle; a later clear wins
        pin_in = 8'hD0;
        repeat (D + 1) tick();
        chg_clr = 8'h20;
        tick();
        check("setclr_fall", fall, 8'h20);
        check("setclr_chg5", chg_flag & 8'h20, 8'h20);
        chg_clr = 8'h00;
        tick();
        chg_clr = 8'h20;
        tick();
        chg_clr = 8'h00;
        check("clr_chg5", chg_flag & 8'h20, 8'h00);
        check("clr_any", 8'(any_chg), 8'h00);

        // Reset mid-count restarts the full latency
        settle(8'h50);
        pin_in = 8'hD0;
        repeat (3) tick();
        do_reset(2);
        for (int e = 1; e <= D + 2; e++) begin
            tick();
            if (e < D + 2) check("midrst_gpi7_low", gpi & 8'h80, 8'h00);
        end
        check("midrst_gpi7", gpi & 8'h80, 8'h80);

        // Random pins, clears and occasional resets
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] flip;
            logic [7:0] cl;
            flip = 8'h00;
            cl   = 8'h00;
            for (int i = 0; i < 8; i++) begin
                flip[i] = ($urandom_range(0, 5) == 0);
                cl[i]   = ($urandom_range(0, 7) == 0);
            end
            pin_in  = pin_in ^ flip;
            chg_clr = cl;
            if ($urandom_range(0, 299) == 0) begin
                do_reset(2);
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpi_input_conditioner.md
Name: gpi_input_conditioner

Overview:
- Sits directly upstream of soft_processor and drives its 8-bit `gpi` bus from raw, asynchronous board pins.
- Per-bit flow: two-flop synchroniser, then a consecutive-cycle debounce filter, then a registered stable value.
- Also produces one-cycle edge pulses and sticky change flags, so firmware can poll for events it would otherwise miss between reads.
- Runs in the processor clock domain; intended clock is 50 MHz (20 ns period).

Parameters:
- WIDTH, 8: number of conditioned input bits; must match the processor `gpi` width.
- DEBOUNCE_CYCLES, 1000: consecutive synchronised cycles an input must differ from the stable value before it is accepted. Legal range 1..65535.
- CNT_W, derived as max(1, clog2(DEBOUNCE_CYCLES)), localparam: debounce counter width.

Ports:
- clk      in   1      processor clock; all state updates on the rising edge
- rst_n    in   1      asynchronous active-low reset, applied to all flops
- pin_in   in   WIDTH  raw asynchronous pin levels
- gpi      out  WIDTH  debounced stable levels; connects to soft_processor `gpi`
- rise     out  WIDTH  one-cycle pulse per bit on a stable 0->1 transition
- fall     out  WIDTH  one-cycle pulse per bit on a stable 1->0 transition
- chg_flag out  WIDTH  sticky per-bit "stable value changed" flags
- chg_clr  in   WIDTH  per-bit clear of chg_flag; level-sampled each cycle
- any_chg  out  1      registered OR-reduction of chg_flag

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - sync1, sync2, stable and counter;
  - outputs gpi, rise, fall, chg_flag and any_chg.
- Reset release: state takes effect on the first rising edge with rst_n high.
- Reset mid-debounce: discards the partial count. A pin already high at release is accepted as a normal 0->1 transition after the full latency, and does raise rise and chg_flag.
- Synchroniser: sync1 <= pin_in, sync2 <= sync1. No logic between the two stages.
- Debounce, per bit i, evaluated each edge:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
- Latency:
  - A pin change settling between edges shows on gpi after rising edge number 2+DEBOUNCE_CYCLES, counting from the first edge after the change.
  - DEBOUNCE_CYCLES=1 gives 3 edges.
- Glitch rejection: any excursion of sync2 that returns before the count completes resets the count. gpi does not change.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- gpi is stable directly, with no extra register stage.
- rise[i] and fall[i]:
  - Registered at the same edge stable[i] updates, so each pulse is high in the first cycle gpi shows the new value.
  - Each pulse lasts exactly one cycle.
  - They are mutually exclusive per bit.
- chg_flag[i]:
  - Set on any stable transition of bit i.
  - Otherwise cleared when chg_clr[i] is high.
  - Set has priority over clear in the same cycle.
  - Holding chg_clr high does not block later sets.
- any_chg: registered from the next-state value of chg_flag, so it updates in the same cycle as chg_flag.
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulses and flags.
- No combinational path from any input to any output.

Decomposition:
- Shared package gpi_cond_pkg holds:
  - GPI_WIDTH = 8;
  - default DEBOUNCE_CYCLES;
  - a function computing CNT_W (max(1, clog2(n))).
- One sub-module, gpi_debounce_bit:
  - Single-bit synchroniser, counter, stable flop, rise/fall registers and chg_flag flop.
  - Instantiated WIDTH times in a generate loop.
- The top level adds only the any_chg reduction and port wiring.

Test Plan (DEBOUNCE_CYCLES=4 override, 20 ns clock):
- Reset behaviour: pin_in=8'hFF held, rst_n low 5 cycles then high. Required response:
  - gpi=8'h00 during reset;
  - gpi=8'hFF at the 6th edge after release;
  - rise=8'hFF for exactly that one cycle;
  - chg_flag=8'hFF and any_chg=1 in that same cycle.
- Clean edge latency: from gpi=8'h00, pin_in[3] 0->1 between edges. Required response:
  - gpi=8'h08 after exactly edge 6;
  - rise=8'h08 one cycle;
  - fall stays 0.
- Glitch reject: pin_in[0] high for 3 cycles then low. Required response: gpi, rise and chg_flag remain 0; the counter returns to 0.
- Simultaneous events: pin_in changes 8'h0F->8'hF0 in one step. Required response:
  - the same cycle shows rise=8'hF0 and fall=8'h0F;
  - chg_flag gains 8'hFF.
- Clear vs set: chg_clr[5] asserted in the same cycle bit 5 transitions. Required response: chg_flag[5] stays 1. A later chg_clr[5] with no transition clears it to 0; any_chg falls once all flags are 0.
- Reset mid-count: pin_in[7] rises, rst_n pulsed low after 3 edges. Required response: gpi[7]=0 through reset, then the full 6-edge latency from release before gpi[7]=1.
